// File: rtl/uart_tx_fsm_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm_if
//
// Bundles the signals between the UART frame sequencer and its neighbours
// (parallel-data source, serializer, parity_calc, TX pin).
//
// Handshake: Data_Valid is a one-cycle strobe with no back-pressure. The
// sequencer answers in the same cycle with data_load=1 when it takes the
// word; a strobe seen while data_load stays 0 is dropped and never queued.
// busy=1 tells the source that a strobe outside the final stop cycle will
// be dropped.
//
// Signals:
//   Data_Valid  src -> fsm   P_DATA valid at serializer/parity_calc
//   PAR_EN      src -> fsm   include parity bit (sampled at accept)
//   ser_data    ser -> fsm   current serializer bit, LSB first
//   parity_bit  par -> fsm   registered parity of the loaded word
//   data_load   fsm -> all   capture P_DATA now
//   ser_en      fsm -> ser   shift enable, high in each data-bit cycle
//   mux_sel     fsm          00 start, 01 stop/idle, 10 data, 11 parity
//   busy        fsm -> src   frame in progress
//   TX_OUT      fsm -> pin   serial line
//   fsm_state   fsm          raw state register, for debug/observation
//
// Modports: master = environment side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface uart_tx_fsm_if;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       ser_data;
    logic       parity_bit;
    logic       data_load;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       busy;
    logic       TX_OUT;
    logic [2:0] fsm_state;

    modport master (
        output Data_Valid, PAR_EN, ser_data, parity_bit,
        input  data_load, ser_en, mux_sel, busy, TX_OUT, fsm_state
    );

    modport slave (
        input  Data_Valid, PAR_EN, ser_data, parity_bit,
        output data_load, ser_en, mux_sel, busy, TX_OUT, fsm_state
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
//
// UART transmit frame sequencer. Accepts a byte-valid strobe, tells the
// serializer and parity_calc to capture the word, then walks one bit per
// CLK cycle through start, WIDTH data bits (LSB first), optional parity and
// the stop bit(s), driving the output-mux select and the serial line.
//
// Parameters:
//   WIDTH       data bits per frame (default 8)
//
// Ports:
//   CLK         bit clock, one UART bit period per cycle
//   RST         synchronous, active-high reset
//   bus         uart_tx_fsm_if.slave (see interface file for signal list)
//
// Build option:
//   UART_TX_TWO_STOP_EN  when defined, frames end with two stop bits
//                        (STOP then STOP2) and back-to-back accept is only
//                        taken in STOP2. When undefined, one stop bit.
//
// Frame timing for an accept in cycle t: start in t+1, data bit i in
// t+2+i, parity (if latched) in t+2+WIDTH, then the stop bit(s).
// -----------------------------------------------------------------------------
module uart_tx_fsm #(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fsm_if.slave  bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] MUX_START  = 2'b00;
    localparam logic [1:0] MUX_STOP   = 2'b01;
    localparam logic [1:0] MUX_DATA   = 2'b10;
    localparam logic [1:0] MUX_PARITY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5
`else
        S_STOP   = 3'd4
`endif
    } state_t;

    // The last stop cycle is the only busy cycle in which a new word may be
    // taken, giving gap-free back-to-back frames.
`ifdef UART_TX_TWO_STOP_EN
    localparam state_t FINAL_STOP = S_STOP2;
`else
    localparam state_t FINAL_STOP = S_STOP;
`endif

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_en_q;
    logic             ser_en_q;
    logic [1:0]       mux_sel_q;
    logic             busy_q;
    logic             accept;

    assign accept = bus.Data_Valid & ((state == S_IDLE) | (state == FINAL_STOP));

    // Moore outputs are registered alongside the state, so every transition
    // below also writes the outputs belonging to the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            ser_en_q  <= 1'b0;
            mux_sel_q <= MUX_STOP;
            busy_q    <= 1'b0;
        end else if (accept) begin
            // Frame shape is frozen here; PAR_EN is ignored until next accept.
            state     <= S_START;
            par_en_q  <= bus.PAR_EN;
            ser_en_q  <= 1'b0;
            mux_sel_q <= MUX_START;
            busy_q    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_IDLE;
                end
                S_START: begin
                    state     <= S_DATA;
                    bit_cnt   <= '0;
                    ser_en_q  <= 1'b1;
                    mux_sel_q <= MUX_DATA;
                    busy_q    <= 1'b1;
                end
                S_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt  <= '0;
                        ser_en_q <= 1'b0;
                        if (par_en_q) begin
                            state     <= S_PARITY;
                            mux_sel_q <= MUX_PARITY;
                        end else begin
                            state     <= S_STOP;
                            mux_sel_q <= MUX_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    state     <= S_STOP;
                    mux_sel_q <= MUX_STOP;
                end
`ifdef UART_TX_TWO_STOP_EN
                S_STOP: begin
                    // First of two stop bits: a strobe here is dropped.
                    state     <= S_STOP2;
                    mux_sel_q <= MUX_STOP;
                    busy_q    <= 1'b1;
                end
                S_STOP2: begin
                    state     <= S_IDLE;
                    mux_sel_q <= MUX_STOP;
                    busy_q    <= 1'b0;
                end
`else
                S_STOP: begin
                    state     <= S_IDLE;
                    mux_sel_q <= MUX_STOP;
                    busy_q    <= 1'b0;
                end
`endif
                default: begin
                    state     <= S_IDLE;
                    ser_en_q  <= 1'b0;
                    mux_sel_q <= MUX_STOP;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_load = accept;
    assign bus.ser_en    = ser_en_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;

    // Line driver: idle/stop high, start low, otherwise pass the data or
    // parity bit through so the line follows the peers without extra delay.
    always_comb begin
        bus.TX_OUT = 1'b1;
        case (mux_sel_q)
            MUX_START:  bus.TX_OUT = 1'b0;
            MUX_STOP:   bus.TX_OUT = 1'b1;
            MUX_DATA:   bus.TX_OUT = bus.ser_data;
            MUX_PARITY: bus.TX_OUT = bus.parity_bit;
            default:    bus.TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fsm
//
// Bench for uart_tx_fsm. Contains simple serializer and parity_calc peers,
// a frame-level reference model (queue of expected per-cycle line slots),
// a table of directed frames, hand-written corner sequences and a random
// phase. Define UART_TX_TWO_STOP_EN on both bench and RTL for two stop bits.
// -----------------------------------------------------------------------------
module tb_uart_tx_fsm;

    localparam int WIDTH = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_tx_fsm_if bus ();

    uart_tx_fsm #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- peers: serializer + parity_calc ----------------
    logic [WIDTH-1:0] p_data  = '0;
    logic             par_inv = 1'b0;   // forces odd parity when set
    logic [WIDTH-1:0] sreg;
    logic             par_reg;

    always @(posedge CLK) begin
        if (RST) begin
            sreg    <= '0;
            par_reg <= 1'b0;
        end else if (bus.data_load) begin
            sreg    <= p_data;
            par_reg <= (^p_data) ^ par_inv;
        end else if (bus.ser_en) begin
            sreg <= sreg >> 1;
        end
    end
    assign bus.ser_data   = sreg[0];
    assign bus.parity_bit = par_reg;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each queued slot is what the line must show in one
    // cycle; front = current cycle. Empty queue means idle.
    typedef struct packed {
        logic       tx;
        logic [1:0] mux;
        logic       se;
    } slot_t;
    slot_t exp_q[$];
    logic  mon_en = 1'b0;

    always @(negedge CLK) begin
        if (mon_en) begin
            logic  acc;
            slot_t cur;
            // A word is taken when idle or when only the last stop bit remains.
            acc = bus.Data_Valid && (exp_q.size() <= 1);
            if (exp_q.size() == 0) cur = '{tx: 1'b1, mux: 2'b01, se: 1'b0};
            else                   cur = exp_q[0];
            check("mon_tx",        bus.TX_OUT,    cur.tx);
            check("mon_mux",       bus.mux_sel,   cur.mux);
            check("mon_ser_en",    bus.ser_en,    cur.se);
            check("mon_busy",      bus.busy,      exp_q.size() != 0);
            check("mon_data_load", bus.data_load, acc);
            if (RST) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (acc) begin
                    exp_q.push_back('{tx: 1'b0, mux: 2'b00, se: 1'b0});
                    for (int i = 0; i < WIDTH; i++)
                        exp_q.push_back('{tx: p_data[i], mux: 2'b10, se: 1'b1});
                    if (bus.PAR_EN)
                        exp_q.push_back('{tx: (^p_data) ^ par_inv, mux: 2'b11, se: 1'b0});
                    for (int i = 0; i < S; i++)
                        exp_q.push_back('{tx: 1'b1, mux: 2'b01, se: 1'b0});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Main flow always sits 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic pe, input logic pi);
        bus.Data_Valid = 1'b1;
        bus.PAR_EN     = pe;
        p_data         = d;
        par_inv        = pi;
        @(negedge CLK);
        check("send_accept", bus.data_load, 1'b1);
        tick();
        bus.Data_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bus.Data_Valid = 1'b0;
        @(negedge CLK);
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("wait_idle_timeout", bus.busy, 1'b0);
        tick();
    endtask

    task automatic capture(input int n, output logic [15:0] bits, output int se_cnt, output int busy_cnt);
        bits = '0; se_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            bits[k] = bus.TX_OUT;
            if (bus.ser_en) se_cnt++;
            if (bus.busy)   busy_cnt++;
            tick();
        end
    endtask

    function automatic logic [15:0] with_stops(input logic [15:0] core, input int len);
        logic [15:0] r = core;
        for (int i = 0; i < S; i++) r[len+i] = 1'b1;
        return r;
    endfunction

    task automatic check_idle(input string name);
        @(negedge CLK);
        check({name, "_tx"},   bus.TX_OUT,  1'b1);
        check({name, "_busy"}, bus.busy,    1'b0);
        check({name, "_mux"},  bus.mux_sel, 2'b01);
        check({name, "_se"},   bus.ser_en,  1'b0);
        tick();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pi;
        logic [15:0] core;      // bit k = line value in frame slot k (start..parity)
        int          core_len;
    } vec_t;
    vec_t tbl[7];

    logic [15:0] bits, bits2;
    int          se_cnt, busy_cnt, busy_low;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 16'h014A, 9};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 16'h014A, 10};
        tbl[2] = '{8'hA5, 1'b1, 1'b1, 16'h034A, 10};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 16'h0078, 9};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 16'h01FE, 10};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 16'h0200, 10};
        tbl[6] = '{8'h01, 1'b1, 1'b0, 16'h0202, 10};

        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        repeat (3) tick();
        RST    = 1'b0;
        mon_en = 1'b1;

        // Reset release, no stimulus: 20 idle cycles.
        for (int i = 0; i < 20; i++) check_idle("reset_idle");

        // Table-driven frames.
        for (int v = 0; v < 7; v++) begin
            wait_idle();
            send(tbl[v].data, tbl[v].pe, tbl[v].pi);
            capture(tbl[v].core_len + S, bits, se_cnt, busy_cnt);
            check("tbl_bits",   bits,     with_stops(tbl[v].core, tbl[v].core_len));
            check("tbl_ser_en", se_cnt,   WIDTH);
            check("tbl_busy",   busy_cnt, tbl[v].core_len + S);
            check_idle("tbl_after");
        end

        // Back-to-back: 0x3C taken in the final stop cycle of an 0xA5 frame.
        wait_idle();
        send(8'hA5, 1'b0, 1'b0);
        bits = '0; busy_low = 0;
        for (int k = 0; k < 9 + S; k++) begin
            bus.Data_Valid = 1'b0;
            if (k == 9 + S - 1) begin
                bus.Data_Valid = 1'b1; p_data = 8'h3C; bus.PAR_EN = 1'b0;
            end
`ifdef UART_TX_TWO_STOP_EN
            if (k == 9) begin
                bus.Data_Valid = 1'b1; p_data = 8'hFF; bus.PAR_EN = 1'b1;
            end
`endif
            @(negedge CLK);
            bits[k] = bus.TX_OUT;
            if (!bus.busy) busy_low++;
            if (k == 9 + S - 1) check("b2b_accept", bus.data_load, 1'b1);
`ifdef UART_TX_TWO_STOP_EN
            if (k == 9) check("b2b_stop1_ignored", bus.data_load, 1'b0);
`endif
            tick();
        end
        bus.Data_Valid = 1'b0;
        check("b2b_first_bits", bits, with_stops(16'h014A, 9));
        capture(9 + S, bits2, se_cnt, busy_cnt);
        check("b2b_second_bits", bits2, with_stops(16'h0078, 9));
        check("b2b_busy_never_low", busy_low + (9 + S - busy_cnt), 0);
        check_idle("b2b_after");

        // Strobe during data bit 3 (slot 4) is dropped.
        wait_idle();
        send(8'hA5, 1'b0, 1'b0);
        bits = '0;
        for (int k = 0; k < 9 + S; k++) begin
            bus.Data_Valid = (k == 4);
            if (k == 4) p_data = 8'h00;
            @(negedge CLK);
            bits[k] = bus.TX_OUT;
            if (k == 4) check("dv_in_data_load", bus.data_load, 1'b0);
            tick();
        end
        bus.Data_Valid = 1'b0;
        check("dv_in_data_bits", bits, with_stops(16'h014A, 9));
        check_idle("dv_in_data_after");

        // Reset at data bit 4 (slot 5) with a strobe in the reset cycle.
        wait_idle();
        send(8'hA5, 1'b0, 1'b0);
        repeat (5) tick();
        RST = 1'b1; bus.Data_Valid = 1'b1; p_data = 8'h5A;
        tick();
        RST = 1'b0; bus.Data_Valid = 1'b0;
        check_idle("rst_mid_next");
        check_idle("rst_dv_dropped");
        send(8'h3C, 1'b1, 1'b0);
        capture(10 + S, bits, se_cnt, busy_cnt);
        check("rst_fresh_bits",   bits,     with_stops(16'h0078, 10));
        check("rst_fresh_ser_en", se_cnt,   WIDTH);

        // Random phase against the model.
        for (int i = 0; i < 1500; i++) begin
            RST            = ($urandom_range(0, 199) == 0);
            bus.Data_Valid = ($urandom_range(0, 3) == 0);
            bus.PAR_EN     = $urandom_range(0, 1);
            par_inv        = $urandom_range(0, 1);
            p_data         = WIDTH'($urandom);
            tick();
        end
        RST = 1'b0;
        wait_idle();
        check_idle("final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame sequencer for the UART transmitter. It accepts a byte-valid strobe and tells the serializer and parity calculator when to capture the word. It then steps through start, data, optional parity and stop bits, one bit per `CLK` cycle. It drives the output-mux select and the serial line, and sits between the parallel-data source and the TX pin, alongside `parity_calc` and the serializer.

## Interface
- `WIDTH`, default 8: data bits per frame; sets the bit-counter range.
- `CLK`  input  1  bit clock, one UART bit period per cycle.
- `RST`  input  1  synchronous, active-high reset.
- `Data_Valid`  input  1  one-cycle strobe: `P_DATA` (at serializer/`parity_calc`) is valid.
- `PAR_EN`  input  1  parity bit included in the frame; sampled at accept.
- `ser_data`  input  1  current serializer output bit, LSB first.
- `parity_bit`  input  1  registered parity from `parity_calc`.
- `data_load`  output  1  accept strobe to serializer and `parity_calc`; capture `P_DATA` now.
- `ser_en`  output  1  serializer shift enable; high for each data-bit cycle.
- `mux_sel`  output  2  encoding: 00 start, 01 stop/idle, 10 data, 11 parity.
- `busy`  output  1  frame in progress.
- `TX_OUT`  output  1  serial line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP (plus STOP2 under macro).
- Accept condition: `data_load = Data_Valid & (state==IDLE | accept-in-final-stop)`. `Data_Valid` in any other state is ignored, with no queuing.
- Accept latches `PAR_EN` into `par_en_q`. Frame shape never changes mid-frame.
- IDLE → START on accept.
- START → DATA unconditionally; `bit_cnt` is cleared to 0.
- DATA: `ser_en`=1. The serializer presents bit `bit_cnt` and shifts on the edge. `bit_cnt` increments modulo `WIDTH`; `bit_cnt` width is clog2(`WIDTH`).
- When `bit_cnt==WIDTH-1`, DATA → PARITY if `par_en_q`, else STOP.
- PARITY → STOP.
- Final stop state: on `Data_Valid` → START (back-to-back, `busy` stays 1). Otherwise → IDLE.
- Moore decode from state:
  - `mux_sel`: START 00, DATA 10, PARITY 11, IDLE/STOP 01.
  - `busy`=1 in every state except IDLE.
- `TX_OUT` is a combinational mux on `mux_sel`: 0 / 1 / `ser_data` / `parity_bit`.

## Timing
- Reset values: state IDLE, `bit_cnt` 0, `par_en_q` 0, `data_load` 0, `ser_en` 0, `mux_sel` 01, `busy` 0, `TX_OUT` 1.
- Accept in cycle t:
  - START bit on `TX_OUT` in t+1.
  - Data bit i in t+2+i.
  - Parity (if enabled) in t+2+`WIDTH`.
  - Stop follows.
- Frame length is 1+`WIDTH`+P+S cycles (P=`par_en_q`, S=stop bits).
- `parity_calc` registers `parity_bit` from data loaded at t. It is stable well before the PARITY cycle, and the FSM does not wait on it.
- `data_load` is combinational from `Data_Valid` and state, in the same cycle as the strobe.
- Back-to-back: an accept in the final stop cycle gives START immediately next cycle, with no idle gap.
- `RST` asserted mid-frame: at the next edge all state returns to reset values and `TX_OUT`=1. The partial frame is abandoned, and `Data_Valid` in the reset cycle is dropped.
- `PAR_EN` toggling mid-frame has no effect until the next accept.

## Configuration
- `UART_TX_TWO_STOP_EN` defined:
  - STOP → STOP2 → (START/IDLE); STOP2 is the final stop state, with `mux_sel` 01.
  - Back-to-back accept is honoured only in STOP2.
  - `Data_Valid` during STOP is ignored.
  - S=2.
- Undefined: STOP is final and STOP2 is not synthesized; S=1.

## Test plan
- Reset release, no stimulus: `TX_OUT`=1, `busy`=0, `mux_sel`=01, `ser_en`=0 for 20 cycles.
- `WIDTH`=8, `PAR_EN`=0, `P_DATA`=0xA5, one `Data_Valid` pulse:
  - `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 (10 cycles).
  - `ser_en` high for exactly 8 cycles; `busy` high for 10 cycles.
- `PAR_EN`=1, 0xA5, bench parity model even (`parity_bit`=0): frame is 0,10100101,0,1. With `parity_bit`=1, the parity slot reads 1.
- Back-to-back: second `Data_Valid` (0x3C) in the stop cycle of the first frame:
  - START of the second frame on the very next cycle.
  - `busy` never drops.
  - Second frame bits 0,0,0,1,1,1,1,0,0,1.
- `Data_Valid` pulsed during DATA bit 3: `data_load`=0 and the frame is unchanged; FSM returns to IDLE after stop.
- `RST` asserted at DATA bit 4 for 1 cycle: next cycle `TX_OUT`=1, `busy`=0, `mux_sel`=01. A fresh `Data_Valid` then produces a full correct frame. With `UART_TX_TWO_STOP_EN`, repeat the 0xA5 frame and check two stop cycles (11 cycles) and that back-to-back works only in the second stop cycle.
